// File: rtl/ps2_keyboard_if.sv
// CPU-side bus of the PS/2 keyboard receiver: strobes, register select, shared data bus and irq.
// The data bus is resolved here; the CPU drives it for writes and the keyboard block while cs_r=1.
interface ps2_keyboard_if;
    logic [1:0] address;
    logic       cs_w;
    logic       cs_r;
    logic [7:0] wr_data;
    logic       wr_oe;
    logic [7:0] rd_data;
    logic       rd_oe;
    logic       irq;
    wire  [7:0] data_bus;

    assign data_bus = rd_oe ? rd_data : (wr_oe ? wr_data : 8'hzz);

    modport master (output address, cs_w, cs_r, wr_data, wr_oe, input data_bus, irq);
    modport slave  (input address, cs_w, cs_r, data_bus, output rd_data, rd_oe, irq);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scan-code FIFO and DATA/STATUS/CTRL byte registers on the CPU bus.
// Optional frame timeout: define PS2_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data=0)
// SHIFT  | collecting 8 data bits, LSB first
// PARITY | checking odd parity over data + parity bit
// STOP   | checking stop bit, then push or flag error
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic clk,
    input logic reset,
    input logic ps2_clk,
    input logic ps2_data,
    ps2_keyboard_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;
    logic       bit_in;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       perr_pend;
    logic       timeout;

    logic       frame_push;
    logic       frame_perr;
    logic       frame_ferr;

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic       empty;
    logic       full;
    logic       push_ok;
    logic       pop;
    logic       flush;

    logic       cs_r_q;
    logic       sel_data_q;
    logic       ie;
    logic       ovf;
    logic       perr;
    logic       ferr;
    logic       wr_status;
    logic       wr_ctrl;
    logic [7:0] rd_mux;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!reset || fall || state == IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout feature TIMEOUT_CYCLES has no effect.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            perr_pend <= 1'b0;
        end else if (timeout) begin
            state <= IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state     <= SHIFT;
                        bit_cnt   <= 3'd0;
                        perr_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    shift_reg <= {bit_in, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= PARITY;
                end
                PARITY: begin
                    perr_pend <= ~(^{bit_in, shift_reg});
                    state     <= STOP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_push = fall && !timeout && state == STOP && bit_in && !perr_pend;
    assign frame_perr = fall && !timeout && state == STOP && bit_in && perr_pend;
    assign frame_ferr = timeout || (fall && state == STOP && !bit_in);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = cs_r_q && !bus.cs_r && sel_data_q && !empty;
    assign push_ok = frame_push && (!full || pop);

    assign wr_status = bus.cs_w && bus.address == 2'd1;
    assign wr_ctrl   = bus.cs_w && bus.address == 2'd2;
    assign flush     = wr_ctrl && bus.data_bus[1];

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Error events win over a write-1-to-clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_r_q     <= 1'b0;
            sel_data_q <= 1'b0;
            ie         <= 1'b0;
            ovf        <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            cs_r_q     <= bus.cs_r;
            sel_data_q <= (bus.address == 2'd0);
            if (wr_ctrl)
                ie <= bus.data_bus[0];
            ovf  <= (frame_push && !push_ok) || (ovf  && !(wr_status && bus.data_bus[3]));
            perr <= frame_perr               || (perr && !(wr_status && bus.data_bus[2]));
            ferr <= frame_ferr               || (ferr && !(wr_status && bus.data_bus[1]));
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (bus.address)
            2'd0: if (!empty) rd_mux = fifo_mem[rd_ptr[PTR_W-1:0]];
            2'd1: rd_mux = {3'b000, ie, ovf, perr, ferr, !empty};
            2'd2: rd_mux = {7'b0000000, ie};
            default: rd_mux = 8'h00;
        endcase
    end

    assign bus.rd_data = rd_mux;
    assign bus.rd_oe   = bus.cs_r && reset;
    assign bus.irq     = ie && !empty;
endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Memory-mapped PS/2 keyboard receiver and bus responder on the shared CPU data/address bus, the input-side counterpart to the video output path.
- Deserialises PS/2 device-to-host frames, buffers scan codes in a FIFO and presents them to the CPU through three byte registers.
- Raises a level interrupt while data is pending.
- Board decode supplies cs_w/cs_r; the block decodes the low address bits itself.

Parameters:
- FIFO_DEPTH, 8: scan-code FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge before an in-progress frame is abandoned (about 2 ms at 25 MHz).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- data_bus  inout  8  shared CPU data bus; driven only while cs_r=1, otherwise high-Z.
- address  input  2  register select, taken from the low CPU address bits.
- cs_w  input  1  write strobe, already qualified with chip select.
- cs_r  input  1  read strobe, already qualified with chip select.
- ps2_clk  input  1  PS/2 clock line, asynchronous.
- ps2_data  input  1  PS/2 data line, asynchronous.
- irq  output  1  high while FIFO is non-empty and IE=1.

Behaviour:
- Input synchronisation:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - A falling edge is the synchronised clk going 1 on the previous cycle and 0 on this cycle.
  - Data is sampled from the synchronised line on the falling-edge cycle.
- Receive FSM, states IDLE, SHIFT, PARITY, STOP:
  - IDLE: on falling edge, data=0 moves to SHIFT with bit count 0; data=1 stays in IDLE (spurious edge).
  - SHIFT: 8 falling edges, data LSB first into an 8-bit shift register, then PARITY.
  - PARITY: sampled bit must make the 9 bits odd parity; a mismatch latches a pending parity error. Then STOP.
  - STOP: sampled bit must be 1.
    - Stop=0: set FERR, discard the byte.
    - Stop=1 with parity error pending: set PERR, discard the byte.
    - Otherwise push the byte into the FIFO.
    - Always return to IDLE.
- FIFO:
  - Push while full drops the new byte, keeps the existing contents and sets OVF.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Register map:
  - addr 0, read DATA: head byte, or 0x00 if empty.
  - addr 1, read STATUS: {3'b0, IE, OVF, PERR, FERR, NE}.
  - addr 1, write: bits 3:1 are write-1-to-clear for OVF/PERR/FERR.
  - addr 2, read/write CTRL: bit0=IE, other bits read 0. Write bit1=1 flushes the FIFO: pointers reset, NE=0; not persistent.
  - addr 3: reads 0x00, writes ignored.
- Read timing:
  - data_bus is driven combinationally from the register selected by address for as long as cs_r=1.
  - A DATA pop occurs once per access, on the first cycle after cs_r falls (registered cs_r=1 and cs_r=0), using the address registered with cs_r.
  - Holding cs_r for N cycles pops exactly one byte. An empty read pops nothing.
- Write timing: takes effect on the rising edge where cs_w=1. Simultaneous cs_w and cs_r: the write takes effect and the read returns the pre-write value.
- Reset (reset=0 sampled at a clock edge):
  - FSM to IDLE, FIFO empty, all flags 0, IE=0, irq=0, data_bus high-Z, synchroniser flops to 1.
  - Mid-frame reset discards the partial frame.

Optional Feature:
- PS2_TIMEOUT_EN defined:
  - A counter clears on every falling edge and while in IDLE, and increments otherwise.
  - Reaching TIMEOUT_CYCLES in SHIFT, PARITY or STOP forces IDLE, sets FERR and discards the partial byte, so a glitched frame cannot desynchronise later frames.
- PS2_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely for edges.

Test Plan:
- After reset, read STATUS -> 0x00 and irq=0. Send a valid frame for 0x1C (parity bit 0). Read STATUS -> 0x01. Read DATA -> 0x1C. STATUS -> 0x00 after the pop.
- IE=1 (write CTRL 0x01). Send 0xF0 then 0x1C -> irq=1 from the push cycle. Two DATA reads return 0xF0 then 0x1C. irq falls after the second pop.
- Send 0x5A with the parity bit inverted -> FIFO stays empty, STATUS=0x04. Write 0x04 to addr 1 -> STATUS=0x00.
- Send FIFO_DEPTH+1 frames (0x01..0x09 with depth 8) -> STATUS=0x09 (OVF, NE). Reads return 0x01..0x08, then 0x00 with NE=0.
- Hold cs_r on DATA for 5 cycles with 2 bytes queued -> exactly one pop; the next read returns the second byte.
- With PS2_TIMEOUT_EN: send start plus 3 data bits, then idle TIMEOUT_CYCLES+2 -> FSM in IDLE, STATUS=0x02. A following valid 0x29 frame is received intact.
